// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: four-way round-robin arbiter with registered index and decoded one-hot grant,
// hold timeout and a one-cycle bubble between owners.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx_n, win;
  logic [7:0] hold_cnt, cnt_n;
  logic valid_n, to_n, expire, release_g;
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  assign expire    = hold_cnt == 8'(MAX_HOLD - 1);
  assign release_g = done | ~req[gnt_idx] | expire;
  // GAP arbitrates on its closing edge so a handoff costs exactly one empty cycle
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    valid_n = gnt_valid;
    cnt_n   = hold_cnt;
    to_n    = 1'b0;
    case (state)
      GRANT: begin
        cnt_n = hold_cnt + 8'd1;
        if (release_g) begin
          valid_n = 1'b0;
          ptr_n   = gnt_idx + 2'd1;
          state_n = GAP;
          to_n    = expire & ~done & req[gnt_idx];
        end
      end
      default: begin
        state_n = IDLE;
        if (en && |req) begin
          idx_n   = win;
          valid_n = 1'b1;
          cnt_n   = 8'd0;
          state_n = GRANT;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= cnt_n;
      gnt       <= valid_n ? 4'b0001 << idx_n : 4'b0000;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      timeout   <= to_n;
      busy      <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed stimulus pushes expected grants; a negedge monitor pops and checks them.
module tb_rr_decode_arbiter;
  logic clk, rst_n, en, done, gnt_valid, timeout, busy;
  logic [3:0] req, gnt;
  logic [1:0] gnt_idx;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] g; logic [1:0] i; int len; logic to; int gap;} exp_t;
  exp_t q[$];
  exp_t cur;
  int len = 0, gap = 0;
  logic pv = 1'b0;

  rr_decode_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] i, input int l, input logic t, input int g);
    exp_t e;
    e.g = 4'b0001 << i; e.i = i; e.len = l; e.to = t; e.gap = g;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (gnt_valid && !pv) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got gnt=%b expected no grant", gnt);
        cur.len = -1; cur.to = 1'b0; cur.gap = -1;
      end else begin
        cur = q.pop_front();
        chk("grant_gnt", int'(gnt), int'(cur.g));
        chk("grant_idx", int'(gnt_idx), int'(cur.i));
        chk("grant_busy", int'(busy), 1);
        if (cur.gap >= 0) chk("gap_cycles", gap, cur.gap);
      end
      len = 1;
    end else if (gnt_valid) begin
      len++;
    end else if (pv) begin
      if (cur.len >= 0) chk("grant_len", len, cur.len);
      chk("timeout_pulse", int'(timeout), int'(cur.to));
      chk("gnt_cleared", int'(gnt), 0);
      gap = 1;
    end else begin
      gap++;
      if (timeout) chk("timeout_stray", int'(timeout), 0);
    end
    pv = gnt_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 4'b0000; done = 1'b0;
    step(2);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    step(1);
    // hold expiry with a single requester
    push(2'd0, 8, 1'b1, -1);
    req = 4'b0001; step(9); req = 4'b0000; step(3);
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    // full rotation with done on the second cycle of each grant
    for (int i = 0; i < 5; i++) push(2'(i), 2, 1'b0, i == 0 ? -1 : 1);
    req = 4'b1111; step(1);
    for (int i = 0; i < 5; i++) begin
      step(1); done = 1'b1;
      step(1); done = 1'b0;
      if (i == 4) req = 4'b0000;
      step(1);
    end
    step(2);
    // wrap search from ptr=2, then ptr=1 chosen from 1010
    push(2'd1, 1, 1'b0, -1);
    push(2'd0, 1, 1'b0, 1);
    push(2'd1, 1, 1'b0, 1);
    req = 4'b0010; step(1); req = 4'b0000; step(1);
    req = 4'b0011; step(1); req = 4'b1010; step(2);
    req = 4'b0000; step(3);
    // done coincides with hold expiry
    push(2'd2, 8, 1'b0, -1);
    req = 4'b0100; step(8); done = 1'b1; step(1); done = 1'b0; req = 4'b0000; step(3);
    // reset mid-grant, then pointer restarts at 0
    push(2'd2, 3, 1'b0, -1);
    push(2'd2, 2, 1'b0, -1);
    req = 4'b0100; step(3); rst_n = 1'b0; step(1);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_valid", int'(gnt_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_timeout", int'(timeout), 0);
    rst_n = 1'b1; req = 4'b1100; step(2); done = 1'b1; step(1); done = 1'b0; req = 4'b0000; step(3);
    // enable gating
    en = 1'b0; req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("en_block", int'(gnt_valid), 0);
    end
    push(2'd1, 3, 1'b0, -1);
    en = 1'b1; step(1); en = 1'b0; step(2); done = 1'b1; step(1);
    done = 1'b0; req = 4'b0000; en = 1'b1; step(5);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
